// File: rtl/rtc_write_sequencer.sv
// Write-side RTC bus sequencer: walks register indices and issues one multiplexed AD write cycle per index.
// Optional feature macro RTC_WR_MASK_EN adds a per-index write mask that skips masked-off registers.
module rtc_write_sequencer #(
  parameter int          N_REGS    = 18,
  parameter int          STRETCH   = 1,
  parameter logic [7:0]  ADDR_BASE = 8'h21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              W_R,
  input  logic              start,
`ifdef RTC_WR_MASK_EN
  input  logic [N_REGS-1:0] wr_mask,
`endif
  input  logic [7:0]        wr_data,
  output logic [4:0]        idx,
  output logic [3:0]        ph,
  output logic              busy,
  output logic              done,
  output logic              cs_n,
  output logic              ale,
  output logic              wr_n,
  output logic              rd_n,
  output logic [7:0]        ad_out,
  output logic              ad_oe
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [4:0] IDX_LAST = 5'(N_REGS - 1);
  localparam logic [3:0] PRE_LAST = 4'(STRETCH - 1);

  state_t     state_reg, state_next;
  logic [4:0] idx_reg, idx_next;
  logic [3:0] ph_reg, ph_next;
  logic [3:0] pre_reg, pre_next;
  logic [7:0] data_reg, data_next;
  logic       cs_n_reg, cs_n_next;
  logic       ale_reg, ale_next;
  logic       wr_n_reg, wr_n_next;
  logic       ad_oe_reg, ad_oe_next;
  logic [7:0] ad_out_reg, ad_out_next;
  logic       abort, advance, skip_cur, skip_next, enter_ph2;
  logic [7:0] addr_next;

  assign abort = !en || W_R;

`ifdef RTC_WR_MASK_EN
  // A masked-off index occupies exactly one clk at ph0 with the bus left idle.
  assign skip_cur  = (state_reg == BUS) && (ph_reg == 4'd0) && !wr_mask[idx_reg];
  assign skip_next = (state_next == BUS) && (ph_next == 4'd0) && !wr_mask[idx_next];
`else
  assign skip_cur  = 1'b0;
  assign skip_next = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    ph_next    = ph_reg;
    pre_next   = pre_reg;
    advance    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = BUS;
          idx_next   = 5'd0;
          ph_next    = 4'd0;
          pre_next   = 4'd0;
        end
      end
      BUS: begin
        if (skip_cur) begin
          advance = 1'b1;
        end else if (pre_reg == PRE_LAST) begin
          pre_next = 4'd0;
          if (ph_reg == 4'd4) advance = 1'b1;
          else                ph_next = ph_reg + 4'd1;
        end else begin
          pre_next = pre_reg + 4'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (advance) begin
      ph_next  = 4'd0;
      pre_next = 4'd0;
      if (idx_reg == IDX_LAST) begin
        state_next = DONE;
        idx_next   = 5'd0;
      end else begin
        idx_next = idx_reg + 5'd1;
      end
    end
    if (abort) begin
      state_next = IDLE;
      idx_next   = 5'd0;
      ph_next    = 4'd0;
      pre_next   = 4'd0;
    end
  end

  // Bus outputs are decoded from the next state so they are valid in the cycle a phase is entered.
  assign addr_next = ADDR_BASE + {3'b000, idx_next};
  assign enter_ph2 = (state_next == BUS) && (ph_next == 4'd2) &&
                     !((state_reg == BUS) && (ph_reg == 4'd2));
  assign data_next = enter_ph2 ? wr_data : data_reg;

  always_comb begin
    cs_n_next   = 1'b1;
    ale_next    = 1'b0;
    wr_n_next   = 1'b1;
    ad_oe_next  = 1'b0;
    ad_out_next = 8'h00;
    if ((state_next == BUS) && !skip_next) begin
      cs_n_next = 1'b0;
      case (ph_next)
        4'd0: begin ale_next = 1'b1; ad_oe_next = 1'b1; ad_out_next = addr_next; end
        4'd1: begin ad_oe_next = 1'b1; ad_out_next = addr_next; end
        4'd2, 4'd3: begin wr_n_next = 1'b0; ad_oe_next = 1'b1; ad_out_next = data_next; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      idx_reg    <= 5'd0;
      ph_reg     <= 4'd0;
      pre_reg    <= 4'd0;
      data_reg   <= 8'h00;
      cs_n_reg   <= 1'b1;
      ale_reg    <= 1'b0;
      wr_n_reg   <= 1'b1;
      ad_oe_reg  <= 1'b0;
      ad_out_reg <= 8'h00;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      ph_reg     <= ph_next;
      pre_reg    <= pre_next;
      data_reg   <= data_next;
      cs_n_reg   <= cs_n_next;
      ale_reg    <= ale_next;
      wr_n_reg   <= wr_n_next;
      ad_oe_reg  <= ad_oe_next;
      ad_out_reg <= ad_out_next;
    end
  end

  assign idx    = idx_reg;
  assign ph     = ph_reg;
  assign busy   = (state_reg == BUS);
  assign done   = (state_reg == DONE);
  assign cs_n   = cs_n_reg;
  assign ale    = ale_reg;
  assign wr_n   = wr_n_reg;
  assign rd_n   = 1'b1;
  assign ad_out = ad_out_reg;
  assign ad_oe  = ad_oe_reg;

endmodule
